// File: rtl/affine_interp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : affine_interp_pkg
// Description : Shared constants, width helpers and the 1/16-phase luma
//               coefficient table for the 8-tap affine interpolator.
// Revision    : 1.0 - initial release
// ============================================================================
package affine_interp_pkg;

    // Beat mode encoding: raw separable sum or final rounded/clipped sample
    localparam logic MODE_RAW   = 1'b0;
    localparam logic MODE_FINAL = 1'b1;

    // Accumulator width: the largest absolute row-coefficient sum is 112 < 2^7
    function automatic int acc_width(input int in_w);
        return in_w + 8;
    endfunction

    // Product width: the largest tap magnitude is 64 = 2^6
    function automatic int prod_width(input int in_w);
        return in_w + 7;
    endfunction

    // Coefficient for phase f, tap k. Phases 9..15 mirror phases 7..1.
    function automatic logic signed [7:0] coef(input logic [3:0] f, input logic [2:0] k);
        logic [4:0] t;
        logic [3:0] ff;
        logic [2:0] kk;
        int         row [8];
        t   = (f > 4'd8) ? (5'd16 - {1'b0, f}) : {1'b0, f};
        ff  = t[3:0];
        kk  = (f > 4'd8) ? (3'd7 - k) : k;
        row = '{0, 0, 0, 64, 0, 0, 0, 0};
        case (ff)
            4'd1:    row = '{ 0, 1,  -3, 63,  4,  -2, 1,  0};
            4'd2:    row = '{-1, 2,  -5, 62,  8,  -3, 1,  0};
            4'd3:    row = '{-1, 3,  -8, 60, 13,  -4, 1,  0};
            4'd4:    row = '{-1, 4, -10, 58, 17,  -5, 1,  0};
            4'd5:    row = '{-1, 4, -11, 52, 26,  -8, 3, -1};
            4'd6:    row = '{-1, 3,  -9, 47, 31, -10, 4, -1};
            4'd7:    row = '{-1, 4, -11, 45, 34, -10, 4, -1};
            4'd8:    row = '{-1, 4, -11, 40, 40, -11, 4, -1};
            default: row = '{ 0, 0,   0, 64,  0,   0, 0,  0};
        endcase
        return 8'(row[kk]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/affine_mcm_tap.sv
`default_nettype none
// ============================================================================
// Module      : affine_mcm_tap
// Description : Combinational shift-add multiplier for one filter tap.
//               All coefficient magnitudes used by this tap are built from a
//               small shared set of partial products, then selected by phase.
// Revision    : 1.0 - initial release
// ============================================================================
module affine_mcm_tap
    import affine_interp_pkg::*;
#(
    parameter int  TAP  = 0,
    parameter int  IN_W = 9,
    localparam int PW   = prod_width(IN_W)
) (
    input  logic signed [IN_W-1:0] i_x,
    input  logic        [3:0]      i_frac,
    output logic signed [PW-1:0]   o_prod
);

    logic signed [PW-1:0] w_x1, w_x2, w_x4, w_x8, w_x16, w_x32, w_x64;
    logic signed [PW-1:0] w_x3, w_x5, w_x9, w_x10, w_x11, w_x13, w_x17;
    logic signed [PW-1:0] w_x26, w_x31, w_x34, w_x40, w_x45, w_x47, w_x52;
    logic signed [PW-1:0] w_x58, w_x60, w_x62, w_x63;

    // Power-of-two terms
    assign w_x1  = {{(PW-IN_W){i_x[IN_W-1]}}, i_x};
    assign w_x2  = w_x1 <<< 1;
    assign w_x4  = w_x1 <<< 2;
    assign w_x8  = w_x1 <<< 3;
    assign w_x16 = w_x1 <<< 4;
    assign w_x32 = w_x1 <<< 5;
    assign w_x64 = w_x1 <<< 6;

    // Shared odd multiples, reused by the larger magnitudes below
    assign w_x3  = w_x1 + w_x2;
    assign w_x5  = w_x1 + w_x4;
    assign w_x9  = w_x1 + w_x8;
    assign w_x11 = w_x9 + w_x2;
    assign w_x13 = w_x9 + w_x4;
    assign w_x17 = w_x16 + w_x1;

    // Derived magnitudes
    assign w_x10 = w_x5 <<< 1;
    assign w_x26 = w_x13 <<< 1;
    assign w_x31 = w_x32 - w_x1;
    assign w_x34 = w_x17 <<< 1;
    assign w_x40 = w_x5 <<< 3;
    assign w_x45 = w_x40 + w_x5;
    assign w_x47 = (w_x3 <<< 4) - w_x1;
    assign w_x52 = w_x13 <<< 2;
    assign w_x58 = w_x64 - (w_x3 <<< 1);
    assign w_x60 = w_x64 - w_x4;
    assign w_x62 = w_x64 - w_x2;
    assign w_x63 = w_x64 - w_x1;

    logic signed [7:0]    w_c;
    logic        [7:0]    w_cabs;
    logic signed [PW-1:0] w_pmag;

    // Select the magnitude for this phase and apply the coefficient sign
    always_comb begin
        w_c    = coef(i_frac, 3'(TAP));
        w_cabs = w_c[7] ? 8'(-w_c) : 8'(w_c);
        w_pmag = '0;
        case (w_cabs)
            8'd1:    w_pmag = w_x1;
            8'd2:    w_pmag = w_x2;
            8'd3:    w_pmag = w_x3;
            8'd4:    w_pmag = w_x4;
            8'd5:    w_pmag = w_x5;
            8'd8:    w_pmag = w_x8;
            8'd9:    w_pmag = w_x9;
            8'd10:   w_pmag = w_x10;
            8'd11:   w_pmag = w_x11;
            8'd13:   w_pmag = w_x13;
            8'd17:   w_pmag = w_x17;
            8'd26:   w_pmag = w_x26;
            8'd31:   w_pmag = w_x31;
            8'd34:   w_pmag = w_x34;
            8'd40:   w_pmag = w_x40;
            8'd45:   w_pmag = w_x45;
            8'd47:   w_pmag = w_x47;
            8'd52:   w_pmag = w_x52;
            8'd58:   w_pmag = w_x58;
            8'd60:   w_pmag = w_x60;
            8'd62:   w_pmag = w_x62;
            8'd63:   w_pmag = w_x63;
            8'd64:   w_pmag = w_x64;
            default: w_pmag = '0;
        endcase
        o_prod = w_c[7] ? -w_pmag : w_pmag;
    end

endmodule
`default_nettype wire

// File: rtl/affine_interp_8tap_pipe.sv
`default_nettype none
// ============================================================================
// Module      : affine_interp_8tap_pipe
// Description : Three-stage pipelined 8-tap 1/16-phase interpolator with
//               valid/ready on both sides. Raw sum for a separable first pass
//               or rounded, shifted and clipped sample for the final pass.
// Revision    : 1.0 - initial release
// ============================================================================
module affine_interp_8tap_pipe
    import affine_interp_pkg::*;
#(
    parameter int  IN_W     = 9,
    parameter int  SHIFT    = 6,
    parameter int  CLIP_MAX = 255,
    localparam int ACC_W    = acc_width(IN_W),
    localparam int PW       = prod_width(IN_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*IN_W-1:0]       in_x,
    input  logic [3:0]              in_frac,
    input  logic                    in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_y
);

    localparam logic signed [ACC_W:0] c_rnd  = (ACC_W+1)'(1 << (SHIFT-1));
    localparam logic signed [ACC_W:0] c_clip = (ACC_W+1)'(CLIP_MAX);

    logic signed [PW-1:0] w_prod [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_tap
            affine_mcm_tap #(
                .TAP  (gi),
                .IN_W (IN_W)
            ) u_tap (
                .i_x    (in_x[gi*IN_W +: IN_W]),
                .i_frac (in_frac),
                .o_prod (w_prod[gi])
            );
        end
    endgenerate

    logic                    r_v1, r_v2, r_v3;
    logic signed [PW-1:0]    r_p1 [8];
    logic                    r_m1, r_m2;
    logic signed [ACC_W-1:0] r_sa, r_sb, r_y;
    logic                    w_en1, w_en2, w_en3;

    // A stage may load when it is empty or its content moves on this cycle
    assign w_en3     = !r_v3 || out_ready;
    assign w_en2     = !r_v2 || w_en3;
    assign w_en1     = !r_v1 || w_en2;
    assign in_ready  = w_en1;
    assign out_valid = r_v3;
    assign out_y     = r_y;

    // Stage occupancy; an empty upstream stage loads a bubble so gaps collapse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_en1) r_v1 <= in_valid;
            if (w_en2) r_v2 <= r_v1;
            if (w_en3) r_v3 <= r_v2;
        end
    end

    // S1: capture the eight tap products and the beat's mode
    always_ff @(posedge clk) begin
        if (w_en1 && in_valid) begin
            for (int i = 0; i < 8; i++) r_p1[i] <= w_prod[i];
            r_m1 <= in_mode;
        end
    end

    logic signed [ACC_W-1:0] w_sa, w_sb;

    // Sign-extend the products and form two 4-tap partial sums
    always_comb begin
        w_sa = ACC_W'(r_p1[0]) + ACC_W'(r_p1[1]) + ACC_W'(r_p1[2]) + ACC_W'(r_p1[3]);
        w_sb = ACC_W'(r_p1[4]) + ACC_W'(r_p1[5]) + ACC_W'(r_p1[6]) + ACC_W'(r_p1[7]);
    end

    // S2: capture the partial sums
    always_ff @(posedge clk) begin
        if (w_en2 && r_v1) begin
            r_sa <= w_sa;
            r_sb <= w_sb;
            r_m2 <= r_m1;
        end
    end

    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W:0]   w_rnd, w_sh, w_clip;
    logic signed [ACC_W-1:0] w_res;

    // Final sum; final mode rounds half up, shifts arithmetically, clamps to [0, CLIP_MAX]
    always_comb begin
        w_sum  = r_sa + r_sb;
        w_rnd  = (ACC_W+1)'(w_sum) + c_rnd;
        w_sh   = w_rnd >>> SHIFT;
        w_clip = w_sh;
        if (w_sh < 0)
            w_clip = '0;
        else if (w_sh > c_clip)
            w_clip = c_clip;
        w_res = (r_m2 == MODE_FINAL) ? w_clip[ACC_W-1:0] : w_sum;
    end

    // S3: output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_y <= '0;
        else if (w_en3 && r_v2)
            r_y <= w_res;
    end

endmodule
`default_nettype wire

// File: tb/tb_affine_interp_8tap_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_affine_interp_8tap_pipe
// Description : Scoreboard bench for affine_interp_8tap_pipe with directed
//               vectors and hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_affine_interp_8tap_pipe;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [71:0]        in_x;
    logic [3:0]         in_frac;
    logic               in_mode;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [16:0] out_y;

    affine_interp_8tap_pipe #(
        .IN_W     (9),
        .SHIFT    (6),
        .CLIP_MAX (255)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_frac   (in_frac),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    always #5 clk = ~clk;

    typedef struct { logic signed [16:0] exp; int acc; bit chk; } sb_t;
    typedef struct { logic [71:0] x; logic [3:0] f; logic m; logic signed [16:0] e; } vec_t;

    sb_t                sb [$];
    vec_t               vl [$];
    int                 tests = 0;
    int                 fails = 0;
    int                 cyc   = 0;
    int                 ready_mode = 0;   // 0: always ready, 1: random, 2: never
    bit                 record = 1'b1;
    bit                 prev_stall = 1'b0;
    logic signed [16:0] prev_y;
    logic signed [16:0] cur_exp;
    bit                 cur_chk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer readiness pattern
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: push on accepted input, pop and compare on delivered output
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                tests++;
                if (!out_valid || out_y !== prev_y) begin
                    fails++;
                    $display("FAIL stall_hold: valid=%0b y=%0d, required valid=1 y=%0d", out_valid, out_y, prev_y);
                end
            end
            if (in_valid && in_ready) sb.push_back('{cur_exp, cyc, cur_chk});
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: got y=%0d with no beat outstanding", out_y);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    if (out_y !== e.exp) begin
                        fails++;
                        $display("FAIL out_y: got %0d, required %0d", out_y, e.exp);
                    end
                    if (e.chk) begin
                        tests++;
                        if (cyc - e.acc != 3) begin
                            fails++;
                            $display("FAIL latency: got %0d cycles, required 3", cyc - e.acc);
                        end
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = out_y;
        end
    end

    function automatic logic [71:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [71:0] r;
        r[0*9 +: 9] = 9'(a0); r[1*9 +: 9] = 9'(a1);
        r[2*9 +: 9] = 9'(a2); r[3*9 +: 9] = 9'(a3);
        r[4*9 +: 9] = 9'(a4); r[5*9 +: 9] = 9'(a5);
        r[6*9 +: 9] = 9'(a6); r[7*9 +: 9] = 9'(a7);
        return r;
    endfunction

    task automatic send(input logic [71:0] x, input logic [3:0] f, input logic m, input logic signed [16:0] e);
        int n = 0;
        in_x = x; in_frac = f; in_mode = m; cur_exp = e; cur_chk = (ready_mode == 0);
        in_valid = 1'b1;
        if (record) vl.push_back('{x, f, m, e});
        @(negedge clk);
        if (ready_mode == 0) begin
            tests++;
            if (!in_ready) begin
                fails++;
                $display("FAIL full_rate: in_ready=0 with consumer always ready, required 1");
            end
        end
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: in_ready=0 for 200 cycles, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d beats outstanding, required 0", sb.size());
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0b, required %0b", name, got, req);
        end
    endtask

    initial begin
        int imp [15] = '{-2, -3, -4, -5, -8, -10, -10, -11, -11, -9, -11, -10, -8, -5, -3};
        rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_frac = '0; in_mode = 1'b0;
        cur_exp = '0; cur_chk = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b1);
        tests++;
        if (out_y !== 17'sd0) begin
            fails++;
            $display("FAIL reset_out_y: got %0d, required 0", out_y);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Constant window: gain 64 on every phase, back to back, mixed modes
        for (int f = 0; f < 16; f++) begin
            send(pk(100, 100, 100, 100, 100, 100, 100, 100), 4'(f), 1'b1, 17'sd100);
            send(pk(100, 100, 100, 100, 100, 100, 100, 100), 4'(f), 1'b0, 17'sd6400);
        end

        // Impulse on tap 5 exposes coef[f][5], including mirrored phases
        for (int f = 1; f < 16; f++)
            send(pk(0, 0, 0, 0, 0, 1, 0, 0), 4'(f), 1'b0, 17'(imp[f-1]));

        // Clipping, rounding and sign handling
        send(pk(0, 0, 0, 255, 255, 0, 0, 0), 4'd8, 1'b1, 17'sd255);
        send(pk(0, 0, 0, 255, 255, 0, 0, 0), 4'd8, 1'b0, 17'sd20400);
        send(pk(255, 0, 255, 0, 0, 255, 0, 255), 4'd8, 1'b0, -17'sd6120);
        send(pk(255, 0, 255, 0, 0, 255, 0, 255), 4'd8, 1'b1, 17'sd0);
        send(pk(0, 0, 0, 1, 0, 0, 0, 0), 4'd8, 1'b1, 17'sd1);
        send(pk(0, 0, 0, -1, 0, 0, 0, 0), 4'd8, 1'b1, 17'sd0);
        send(pk(0, 0, 0, -1, 0, 0, 0, 0), 4'd8, 1'b0, -17'sd40);
        send(pk(0, 0, 0, 200, 0, 0, 0, 0), 4'd0, 1'b1, 17'sd200);
        send(pk(-256, -256, -256, -256, -256, -256, -256, -256), 4'd5, 1'b0, -17'sd16384);
        send(pk(0, 10, 20, 30, 40, 50, 60, 70), 4'd4, 1'b0, 17'sd2070);
        send(pk(0, 10, 20, 30, 40, 50, 60, 70), 4'd4, 1'b1, 17'sd32);
        send(pk(0, 10, 20, 30, 40, 50, 60, 70), 4'd12, 1'b0, 17'sd2410);
        send(pk(0, 10, 20, 30, 40, 50, 60, 70), 4'd12, 1'b1, 17'sd38);
        drain();

        // Backpressure: replay known vectors with random stalls and input gaps
        record = 1'b0;
        ready_mode = 1;
        for (int i = 0; i < 20; i++) begin
            vec_t v;
            v = vl[(i * 7 + 3) % vl.size()];
            send(v.x, v.f, v.m, v.e);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        drain();

        // Reset with a full pipeline held by a stalled consumer
        ready_mode = 2;
        repeat (2) begin
            @(posedge clk); #1;
        end
        send(pk(0, 0, 0, 1, 0, 0, 0, 0), 4'd8, 1'b1, 17'sd1);
        send(pk(0, 0, 0, 200, 0, 0, 0, 0), 4'd0, 1'b1, 17'sd200);
        send(pk(0, 0, 0, -1, 0, 0, 0, 0), 4'd8, 1'b0, -17'sd40);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("pre_reset_valid", out_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("async_reset_valid", out_valid, 1'b0);
        tests++;
        if (out_y !== 17'sd0) begin
            fails++;
            $display("FAIL async_reset_y: got %0d, required 0", out_y);
        end
        sb.delete();
        prev_stall = 1'b0;
        ready_mode = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk1("no_stale_output", out_valid, 1'b0);
        send(pk(0, 10, 20, 30, 40, 50, 60, 70), 4'd12, 1'b1, 17'sd38);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
